debouncer_multi: RTL and testbench

//  N-channel push-button debouncer and one-shot generator for the UART front panel.

---
 rtl/debouncer_multi.sv | 114 +++++++++++
 tb/tb_debouncer_multi.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// N-channel push-button debouncer with one-shot press pulses and per-channel hold-off FSMs.
// Optional auto-repeat while held: define DEBOUNCE_REPEAT_EN.
module debouncer_multi #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DELAY  = 4,
  parameter int unsigned REPEAT = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [N_CH-1:0] Switch,
  output logic [N_CH-1:0] One_Shot,
  output logic [N_CH-1:0] Pressed,
  output logic [N_CH-1:0] Busy
);

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned CNT_MAX = (DELAY > REPEAT) ? DELAY : REPEAT;
`else
  localparam int unsigned CNT_MAX = DELAY;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  if (N_CH < 1 || DELAY < 1 || REPEAT < 2) begin : g_bad_params
    $error("debouncer_multi: illegal parameters");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SHOT = 3'd1,
    OFF1 = 3'd2,
    HELD = 3'd3,
    OFF2 = 3'd4
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shot_q, shot_d;
    logic             pressed_q, pressed_d;
    logic             busy_q, busy_d;
    logic             dly_done;
    logic             rpt_fire;

    assign dly_done = (cnt_q == CNT_W'(DELAY - 1));

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        shot_q    <= 1'b0;
        pressed_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        shot_q    <= shot_d;
        pressed_q <= pressed_d;
        busy_q    <= busy_d;
      end
    end

    // Next state and counter; outputs are registered from the next state so they follow the state exactly.
    always_comb begin
      state_d  = IDLE;
      cnt_d    = '0;
      rpt_fire = 1'b0;
      case (state_q)
        IDLE: state_d = (Switch[g] && Enable) ? SHOT : IDLE;
        SHOT: state_d = OFF1;
        OFF1: begin
          if (dly_done) begin
            state_d = HELD;
          end else begin
            state_d = OFF1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!Switch[g]) begin
            state_d = OFF2;
          end else begin
            state_d = HELD;
`ifdef DEBOUNCE_REPEAT_EN
            if (cnt_q == CNT_W'(REPEAT - 1)) begin
              rpt_fire = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        OFF2: begin
          if (dly_done) begin
            state_d = IDLE;
          end else begin
            state_d = OFF2;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      shot_d    = (state_d == SHOT) || rpt_fire;
      pressed_d = (state_d == SHOT) || (state_d == OFF1) || (state_d == HELD);
      busy_d    = (state_d == OFF1) || (state_d == OFF2);
    end

    assign One_Shot[g] = shot_q;
    assign Pressed[g]  = pressed_q;
    assign Busy[g]     = busy_q;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi (N_CH=2, DELAY=4, REPEAT=8); expected per-cycle
// channel states are written by hand as letters: I idle, S shot, A off1, H held, B off2, R repeat pulse.
module tb_debouncer_multi;
  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [1:0] Switch;
  logic [1:0] One_Shot;
  logic [1:0] Pressed;
  logic [1:0] Busy;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [5:0] exp_q[$];
  string      tag_q[$];
  logic [5:0] mon_exp;
  logic [5:0] mon_act;
  string      mon_tag;
  event       mon_ev;

  always #5 Clock = ~Clock;

  debouncer_multi #(.N_CH(2), .DELAY(4), .REPEAT(8)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .Switch  (Switch),
    .One_Shot(One_Shot),
    .Pressed (Pressed),
    .Busy    (Busy)
  );

  // Letter -> {one_shot, pressed, busy}
  function automatic logic [2:0] dec(byte c);
    case (c)
      "S", "R": return 3'b110;
      "A":      return 3'b011;
      "H":      return 3'b010;
      "B":      return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic string rep(string s, int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  function automatic logic [5:0] pack_exp(byte c0, byte c1);
    logic [2:0] e0 = dec(c0);
    logic [2:0] e1 = dec(c1);
    return {e1[2], e0[2], e1[1], e0[1], e1[0], e0[0]};
  endfunction

  task automatic run_seq(string name, string sw0, string sw1, string en, string ex0, string ex1);
    for (int i = 0; i < sw0.len(); i++) begin
      Switch = {sw1[i] == "1", sw0[i] == "1"};
      Enable = (en[i] == "1");
      @(posedge Clock);
      exp_q.push_back(pack_exp(ex0[i], ex1[i]));
      tag_q.push_back($sformatf("%s[%0d]", name, i));
      #1;
    end
  endtask

  // Monitor: compare one expectation per falling edge (or on demand for asynchronous checks).
  always @(negedge Clock or mon_ev) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {One_Shot, Pressed, Busy};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL %s: {one_shot,pressed,busy} got %b expected %b", mon_tag, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset  = 1'b1;
    Enable = 1'b1;
    Switch = 2'b00;
    #12;
    run_seq("reset", "11", "11", "11", "II", "II");
    Reset = 1'b0;
    run_seq("idle", "00", "00", "11", "II", "II");

    // Single press held 20 cycles
    run_seq("press", {rep("1", 20), rep("0", 6)}, rep("0", 26), rep("1", 26),
            {"SAAAA", rep("H", 15), "BBBB", "II"}, rep("I", 26));

    // Bounce during OFF1 is masked
    run_seq("bounce", {"10101", "111", rep("0", 6)}, rep("0", 14), rep("1", 14),
            {"S", rep("A", 4), rep("H", 3), rep("B", 4), "II"}, rep("I", 14));

    // Simultaneous presses, ch1 released early
    run_seq("dual", {rep("1", 12), rep("0", 6)}, {rep("1", 5), rep("0", 13)}, rep("1", 18),
            {"S", rep("A", 4), rep("H", 7), rep("B", 4), "II"},
            {"S", rep("A", 4), "H", rep("B", 4), rep("I", 8)});

    // Enable low blocks the press; raising it while held starts SHOT
    run_seq("enable", rep("0", 17), {rep("1", 11), rep("0", 6)}, {"0000", rep("1", 13)},
            rep("I", 17), {"IIII", "S", rep("A", 4), "HH", rep("B", 4), "II"});

    // Switch high at OFF2 end: back to IDLE, then a new SHOT
    run_seq("rearm", {rep("1", 6), "0", rep("1", 10), rep("0", 6)}, rep("0", 23), rep("1", 23),
            {"S", rep("A", 4), "H", rep("B", 4), "I", "S", rep("A", 4), "H", rep("B", 4), "II"},
            rep("I", 23));

    // Asynchronous reset in the middle of OFF1
    run_seq("pre_rst", "111", "000", "111", "SAA", "III");
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    if ({One_Shot, Pressed, Busy} !== 6'b000000) begin
      miscompares++;
      $display("FAIL async_reset_direct: got %b expected 000000", {One_Shot, Pressed, Busy});
    end
    exp_q.push_back(6'b000000);
    tag_q.push_back("async_reset");
    -> mon_ev;
    run_seq("in_rst", "0", "0", "1", "I", "I");
    if (Pressed[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL in_rst: Pressed[0] got %b expected 0", Pressed[0]);
    end
    Reset = 1'b0;
    run_seq("post_rst", {"000", rep("1", 6), rep("0", 6)}, rep("0", 15), rep("1", 15),
            {"III", "S", rep("A", 4), "H", rep("B", 4), "II"}, rep("I", 15));

`ifdef DEBOUNCE_REPEAT_EN
    // Auto-repeat every REPEAT cycles after HELD entry
    run_seq("repeat40", {rep("1", 46), rep("0", 6)}, rep("0", 52), rep("1", 52),
            {"S", rep("A", 4), "H", rep("HHHHHHHR", 5), rep("B", 4), "II"}, rep("I", 52));
    run_seq("repeat12", {rep("1", 17), rep("0", 6)}, rep("0", 23), rep("1", 23),
            {"S", rep("A", 4), rep("H", 8), "R", rep("H", 3), rep("B", 4), "II"}, rep("I", 23));
`endif

    repeat (3) @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations never compared", exp_q.size());
    end
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no vectors compared");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) begin
      $fatal(1, "FAIL: %0d miscompares", miscompares);
    end
    $display("PASS");
    $finish;
  end
endmodule
